// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scancode sequencer.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;
endpackage

// File: rtl/ps2_event_fifo.sv
// Small key-event FIFO; head is zero while empty so idle outputs read as 0.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  ps2_event_t push_ev,
  input  logic       pop,
  output ps2_event_t head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  ps2_event_t      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ev;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 Set-2 byte sequencer: E0/F0 prefix FSM, prefix watchdog, event FIFO.
// Define PS2_REPEAT_FILTER_EN to suppress typematic repeats of the held key.
module ps2_scancode_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scancode,
  input  logic       valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic       err
);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state_q, state_d;
  logic [WW-1:0] wdog_q;
  logic          err_q, err_d, ovf_q;
  logic          push_req, push, timeout, full, empty, pop, drop;
  ps2_event_t    push_ev, head;

  assign timeout = !valid && (state_q != IDLE) && (wdog_q == WD_MAX);

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    push_ev  = '0;
    err_d    = 1'b0;
    if (valid) begin
      if (scancode == PS2_ERR0 || scancode == PS2_ERR1) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else if (scancode == PS2_EXT) begin
        state_d = (state_q == IDLE || state_q == EXT) ? EXT : EXT_BRK;
      end else if (scancode == PS2_BRK) begin
        state_d = (state_q == IDLE || state_q == BRK) ? BRK : EXT_BRK;
      end else begin
        push_req = 1'b1;
        push_ev  = '{ext:  (state_q == EXT || state_q == EXT_BRK),
                     brk:  (state_q == BRK || state_q == EXT_BRK),
                     code: scancode};
        state_d  = IDLE;
      end
    end else if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [8:0] held_q;
  logic       held_v_q, held_hit, is_rep;

  assign held_hit = held_v_q && (held_q == {push_ev.ext, push_ev.code});
  assign is_rep   = push_req && !push_ev.brk && held_hit;
  assign push     = push_req && !is_rep;

  always_ff @(posedge clk) begin
    if (!rst) begin
      held_q   <= '0;
      held_v_q <= 1'b0;
    end else if (push_req) begin
      if (!push_ev.brk && !is_rep) begin
        held_q   <= {push_ev.ext, push_ev.code};
        held_v_q <= 1'b1;
      end else if (push_ev.brk && held_hit) begin
        held_v_q <= 1'b0;
      end
    end
  end
`else
  assign push = push_req;
`endif

  assign pop  = ev_valid && ev_ready;
  assign drop = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wdog_q  <= (valid || state_q == IDLE || timeout) ? '0 : wdog_q + 1'b1;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)              ovf_q <= 1'b1;
      else if (clr_overflow) ovf_q <= 1'b0;
    end
  end

  ps2_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_ev (push_ev),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  assign ev_valid = !empty;
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_brk   = head.brk;
  assign overflow = ovf_q;
  assign err      = err_q;
endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Bench for ps2_scancode_ctrl: vector table plus corner-case sequences, scoreboard on pops.
module tb_ps2_scancode_ctrl;
  import ps2_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst, valid, ev_valid, ev_ready, ev_ext, ev_brk, overflow, clr_overflow, err;
  logic [7:0] scancode, ev_code;

  int n_chk = 0;
  int n_err = 0;
  ps2_event_t exp_q [$];

  typedef struct {
    logic [7:0] sc;
    bit         push;
    ps2_event_t ev;
  } vec_t;
  vec_t vecs [$];

  always #5 clk = ~clk;

  ps2_scancode_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .scancode     (scancode),
    .valid        (valid),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_code      (ev_code),
    .ev_ext       (ev_ext),
    .ev_brk       (ev_brk),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .err          (err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic ps2_event_t mk(input logic e, input logic b, input logic [7:0] c);
    ps2_event_t t;
    t.ext = e; t.brk = b; t.code = c;
    return t;
  endfunction

  task automatic add(input logic [7:0] sc, input bit p, input ps2_event_t ev);
    vec_t v;
    v.sc = sc; v.push = p; v.ev = ev;
    vecs.push_back(v);
  endtask

  // Caller sits 1 time unit after a rising edge; returns likewise.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    scancode = b;
    valid    = 1'b1;
    tick(1);
    valid    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    valid = 1'b0;
    clr_overflow = 1'b0;
    tick(2);
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    ev_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || ev_valid); i++) tick(1);
    chk(name, exp_q.size(), 0);
    chk({name, "_empty"}, ev_valid, 1'b0);
  endtask

  // Scoreboard: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (rst === 1'b1 && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_event: got %0h expected none", {ev_ext, ev_brk, ev_code});
      end else begin
        ps2_event_t e;
        e = exp_q.pop_front();
        chk("event", {ev_ext, ev_brk, ev_code}, e);
      end
    end
  end

  initial begin
    int wait_i;
    rst = 1'b0; valid = 1'b0; scancode = '0; ev_ready = 1'b0; clr_overflow = 1'b0;
    tick(2);
    chk("rst_ev_valid", ev_valid, 1'b0);
    chk("rst_ev_word", {ev_ext, ev_brk, ev_code}, '0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b1;

    // Decode table, consumer always ready.
    add(8'h1C, 1, mk(0, 0, 8'h1C));
    add(8'hE0, 0, '0); add(8'h75, 1, mk(1, 0, 8'h75));
    add(8'hF0, 0, '0); add(8'h1C, 1, mk(0, 1, 8'h1C));
    add(8'hE0, 0, '0); add(8'hF0, 0, '0); add(8'h75, 1, mk(1, 1, 8'h75));
    add(8'hF0, 0, '0); add(8'hE0, 0, '0); add(8'h6B, 1, mk(1, 1, 8'h6B));
    add(8'hE0, 0, '0); add(8'hE0, 0, '0); add(8'h74, 1, mk(1, 0, 8'h74));
    add(8'hF0, 0, '0); add(8'hF0, 0, '0); add(8'h29, 1, mk(0, 1, 8'h29));
    ev_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].push) exp_q.push_back(vecs[i].ev);
      send(vecs[i].sc);
    end
    drain("table");

    // Single make: one-cycle latency, pop clears.
    do_reset();
    ev_ready = 1'b0;
    exp_q.push_back(mk(0, 0, 8'h1C));
    send(8'h1C);
    chk("t1_valid", ev_valid, 1'b1);
    chk("t1_word", {ev_ext, ev_brk, ev_code}, {2'b00, 8'h1C});
    ev_ready = 1'b1;
    tick(1);
    chk("t1_popped", ev_valid, 1'b0);
    chk("t1_sb", exp_q.size(), 0);

    // Extended break holds under back-pressure, FSM returns to IDLE.
    ev_ready = 1'b0;
    send(8'hE0); send(8'hF0); send(8'h75);
    tick(3);
    chk("t2_hold_valid", ev_valid, 1'b1);
    chk("t2_hold_word", {ev_ext, ev_brk, ev_code}, {2'b11, 8'h75});
    exp_q.push_back(mk(1, 1, 8'h75));
    exp_q.push_back(mk(0, 0, 8'h1D));
    send(8'h1D);
    drain("t2");

    // Overflow, clear/drop priority, full push+pop.
    do_reset();
    ev_ready = 1'b0;
    exp_q.push_back(mk(0, 0, 8'h15)); send(8'h15);
    exp_q.push_back(mk(0, 0, 8'h16)); send(8'h16);
    exp_q.push_back(mk(0, 0, 8'h1A)); send(8'h1A);
    chk("t3_no_ovf_yet", overflow, 1'b0);
    exp_q.push_back(mk(0, 0, 8'h1B)); send(8'h1B);
    chk("t3_full_no_ovf", overflow, 1'b0);
    send(8'h1C);
    chk("t3_ovf_set", overflow, 1'b1);
    clr_overflow = 1'b1;
    send(8'h22);
    clr_overflow = 1'b0;
    chk("t3_drop_beats_clr", overflow, 1'b1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    chk("t3_clr", overflow, 1'b0);
    ev_ready = 1'b1;
    exp_q.push_back(mk(0, 0, 8'h21));
    send(8'h21);
    ev_ready = 1'b0;
    chk("t3_full_pushpop_no_ovf", overflow, 1'b0);
    chk("t3_head_after_pop", ev_code, 8'h16);
    drain("t3");

    // Watchdog abort after a lone F0.
    do_reset();
    ev_ready = 1'b1;
    send(8'hF0);
    wait_i = 40;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (err) begin
        wait_i = i;
        break;
      end
    end
    chk("t4_wdog_latency", wait_i, TMO - 1);
    tick(1);
    chk("t4_err_pulse", err, 1'b0);
    exp_q.push_back(mk(0, 0, 8'h1C));
    send(8'h1C);
    drain("t4");

    // Error byte mid-sequence.
    do_reset();
    ev_ready = 1'b1;
    send(8'hE0);
    send(8'hFF);
    chk("t5_err", err, 1'b1);
    chk("t5_no_push", ev_valid, 1'b0);
    exp_q.push_back(mk(0, 0, 8'h1C));
    send(8'h1C);
    chk("t5_err_clear", err, 1'b0);
    drain("t5");

    // Typematic repeats.
    do_reset();
    ev_ready = 1'b1;
    exp_q.push_back(mk(0, 0, 8'h1C));
`ifdef PS2_REPEAT_FILTER_EN
    exp_q.push_back(mk(0, 1, 8'h1C));
    exp_q.push_back(mk(0, 0, 8'h1C));
`else
    exp_q.push_back(mk(0, 0, 8'h1C));
    exp_q.push_back(mk(0, 0, 8'h1C));
    exp_q.push_back(mk(0, 1, 8'h1C));
    exp_q.push_back(mk(0, 0, 8'h1C));
`endif
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    drain("t6");

    // Reset mid-E0 with FIFO occupied discards everything.
    ev_ready = 1'b0;
    send(8'h1C);
    send(8'hE0);
    rst = 1'b0;
    tick(1);
    chk("t7_valid", ev_valid, 1'b0);
    chk("t7_word", {ev_ext, ev_brk, ev_code}, '0);
    chk("t7_ovf_err", {overflow, err}, 2'b00);
    rst = 1'b1;
    exp_q.delete();
    exp_q.push_back(mk(0, 0, 8'h1C));
    send(8'h1C);
    drain("t7");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
